jtag_mm_cmd_master: RTL and testbench
=====================================

# jtag_mm_cmd_master

Byte-protocol command decoder and Avalon-MM master that sits directly behind `altera_jtag_fifo`. It consumes host bytes from the FIFO's receive side and parses fixed-length read/write frames. It issues single 32-bit bus transactions and serialises the response bytes back into the FIFO's transmit side. It lets a JTAG host peek and poke any memory-mapped slave in the design.

## Interface
- `TIMEOUT_CYCLES`, 65535: maximum idle cycles between bytes inside a frame before the frame is abandoned (1..65535).
- `ACK_BYTE`, 8'hA5: response byte for a completed write.
- `NAK_BYTE`, 8'hEE: response byte for an unknown command byte.

Ports (clock and reset first):
- `clk`  in  1  single system clock, shared with `altera_jtag_fifo`.
- `rst`  in  1  synchronous, active-high reset.
- `rx_dataavailable`  in  1  FIFO receive side non-empty; the FIFO pops unconditionally.
- `rx_readdata`  in  8  byte popped in the previous cycle.
- `tx_write`  out  1  single-cycle byte write request to the FIFO.
- `tx_writedata`  out  8  byte accompanying `tx_write`.
- `tx_readyfordata`  in  1  FIFO transmit side not full.
- `avm_address`  out  32  byte address.
- `avm_read`  out  1  read request, held until accepted.
- `avm_write`  out  1  write request, held until accepted.
- `avm_writedata`  out  32  write data.
- `avm_readdata`  in  32  read data, valid while `avm_read` is high and `avm_waitrequest` is low.
- `avm_waitrequest`  in  1  slave stall.
- `err_overrun`  out  1  one-cycle pulse: a byte was dropped.
- `err_badcmd`  out  1  one-cycle pulse: an unknown command was received.
- `err_timeout`  out  1  one-cycle pulse: a frame was abandoned.

## Operation
- **Receive rule.** `rx_dataavailable` high in cycle N means a byte is valid on `rx_readdata` in cycle N+1 and must be consumed then; there is no backpressure. The block registers `rx_dataavailable` to form an internal `rx_valid`.
- **Frame format.** Command byte first, then address A[31:24], A[23:16], A[15:8], A[7:0], big-endian. A write frame continues with data D[31:24]..D[7:0].
- **Command bytes.**
  - 8'h00: read word. Response is 4 bytes of read data, MSB first.
  - 8'h01: write word. Response is `ACK_BYTE`.
  - Any other value: respond `NAK_BYTE`, pulse `err_badcmd`, return to IDLE.
- **State machine states:** IDLE, ADDR, WDATA, BUS, RESP.
  - IDLE: a valid byte decodes the command. 00 or 01 -> ADDR with byte count 0. Unknown -> RESP with 1 byte queued.
  - ADDR: 4 bytes are shifted into the address register. After the 4th byte: read -> BUS; write -> WDATA.
  - WDATA: 4 bytes are shifted into the write-data register, then -> BUS.
  - BUS: `avm_read` or `avm_write` is asserted and held until a cycle with `avm_waitrequest`=0. On read, `avm_readdata` is captured in that cycle. The request deasserts in the next cycle; state -> RESP.
  - RESP: response bytes are emitted in order. After the last byte -> IDLE.
- **Dropped bytes.** Any byte received in BUS or RESP is dropped and `err_overrun` pulses. The host must wait for the response before sending the next frame.
- **Timeout.** In ADDR or WDATA, a 16-bit gap counter resets on each byte and increments otherwise. On reaching `TIMEOUT_CYCLES` the frame is discarded with no response, `err_timeout` pulses, and the state returns to IDLE.

## Timing
- **Reset values.** On `rst`, all outputs are driven 0, including `avm_address`, `avm_writedata` and `tx_writedata`. State goes to IDLE and all counters clear.
- **Reset mid-frame or mid-bus.** Reset aborts immediately. `avm_read`/`avm_write` drop in the cycle after `rst` is sampled high.
- **TX write rule.** `tx_write` is asserted only in a cycle where `tx_readyfordata`=1. After each `tx_write` cycle, at least one cycle without `tx_write` follows. This is required because the FIFO's full flag lags its registered write by one cycle.
- **TX throughput.** Maximum rate is 1 byte per 2 cycles. If `tx_readyfordata`=0, the current byte is held and retried; nothing is lost.
- **Bus latency.** `avm_read`/`avm_write` rise in the cycle after the last frame byte is consumed.
- **Response latency.** The first `tx_write` occurs no earlier than the cycle after the bus request deasserts.
- **Zero-wait bus.** With `avm_waitrequest` tied 0, the request is exactly 1 cycle wide.
- **Simultaneous events.** A byte arriving in the same cycle the timeout count would expire is accepted, and no timeout is reported.
- **Error flags.** Each error flag is high for exactly 1 cycle per event.

## Test plan
- **Write frame.** Bytes 01 00 00 10 00 DE AD BE EF with `avm_waitrequest`=0 -> exactly one `avm_write` cycle with address 32'h0000_1000 and data 32'hDEAD_BEEF; then one `tx_write` of 8'hA5; state returns to IDLE.
- **Read frame with stall.** Bytes 00 00 00 10 00, `avm_waitrequest` held high 5 cycles, `avm_readdata`=32'h1234_5678 when released -> `avm_read` high for 6 cycles; then `tx_write` bytes 12, 34, 56, 78 with at least 1 idle cycle between each.
- **Unknown command.** Byte 7F -> one `tx_write` of 8'hEE and one `err_badcmd` pulse. A following valid read frame then completes normally.
- **Timeout.** `TIMEOUT_CYCLES`=20; send 01 00 00, then idle 20 cycles -> `err_timeout` pulses once and no bus access occurs. A subsequent full write frame succeeds.
- **Overrun and TX backpressure.** During a BUS stall, inject byte 55 -> `err_overrun` pulses once. Hold `tx_readyfordata`=0 for 10 cycles during RESP -> no `tx_write` while it is low, and all 4 read bytes are delivered in order afterwards.
- **Reset mid-operation.** Assert `rst` for 1 cycle while `avm_read` is waiting -> all outputs are 0 the next cycle. A following new frame is processed correctly.

Source files
------------

// File: rtl/jtag_mm_cmd_master.sv
// jtag_mm_cmd_master: byte-framed peek/poke command decoder and Avalon-MM
// master sitting between altera_jtag_fifo's rx/tx sides and the system bus.
module jtag_mm_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter logic [7:0]  ACK_BYTE       = 8'hA5,
   parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_dataavailable,
   input  logic [7:0]  rx_readdata,
   output logic        tx_write,
   output logic [7:0]  tx_writedata,
   input  logic        tx_readyfordata,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        err_overrun,
   output logic        err_badcmd,
   output logic        err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_BUS,
      S_RESP
   } state_t;

   localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   state_t      state_d;
   logic        rx_valid;
   logic        is_write;
   logic [1:0]  byte_cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] resp_q;
   logic [2:0]  resp_len;
   logic [15:0] gap_q;
   logic        tx_hold;
   logic        cmd_known;
   logic        in_frame;
   logic        last_byte;
   logic        timeout_hit;

   assign cmd_known   = (rx_readdata[7:1] == 7'd0);
   assign in_frame    = (state_q == S_ADDR) || (state_q == S_WDATA);
   assign last_byte   = rx_valid && (byte_cnt == 2'd3);
   // A byte landing on the expiry cycle wins over the timeout.
   assign timeout_hit = in_frame && !rx_valid && (gap_q == GAP_LAST);

   assign avm_address   = addr_q;
   assign avm_writedata = wdata_q;
   assign tx_writedata  = resp_q[31:24];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               state_d = cmd_known ? S_ADDR : S_RESP;
            end
         end
         S_ADDR: begin
            unique case (1'b1)
               last_byte:   state_d = is_write ? S_WDATA : S_BUS;
               timeout_hit: state_d = S_IDLE;
               default:     state_d = S_ADDR;
            endcase
         end
         S_WDATA: begin
            unique case (1'b1)
               last_byte:   state_d = S_BUS;
               timeout_hit: state_d = S_IDLE;
               default:     state_d = S_WDATA;
            endcase
         end
         S_BUS: begin
            if (!avm_waitrequest) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (tx_write && (resp_len == 3'd1)) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      avm_read  = 1'b0;
      avm_write = 1'b0;
      tx_write  = 1'b0;
      unique case (state_q)
         S_BUS: begin
            avm_read  = !is_write;
            avm_write = is_write;
         end
         S_RESP:  tx_write = tx_readyfordata && !tx_hold;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_valid    <= 1'b0;
         is_write    <= 1'b0;
         byte_cnt    <= 2'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         resp_q      <= '0;
         resp_len    <= 3'd0;
         gap_q       <= '0;
         tx_hold     <= 1'b1;
         err_overrun <= 1'b0;
         err_badcmd  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         rx_valid    <= rx_dataavailable;
         // FIFO full flag lags a write by one cycle, so always skip one.
         tx_hold     <= tx_write || (state_q != S_RESP);
         err_badcmd  <= 1'b0;
         err_timeout <= timeout_hit;
         err_overrun <= rx_valid &&
                        ((state_q == S_BUS) || (state_q == S_RESP));
         if (in_frame && !rx_valid) begin
            gap_q <= gap_q + 16'd1;
         end else begin
            gap_q <= '0;
         end
         unique case (state_q)
            S_IDLE: begin
               if (rx_valid) begin
                  byte_cnt <= 2'd0;
                  is_write <= rx_readdata[0];
                  if (!cmd_known) begin
                     resp_q     <= {NAK_BYTE, 24'h0};
                     resp_len   <= 3'd1;
                     err_badcmd <= 1'b1;
                  end
               end
            end
            S_ADDR: begin
               if (rx_valid) begin
                  addr_q   <= {addr_q[23:0], rx_readdata};
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            S_WDATA: begin
               if (rx_valid) begin
                  wdata_q  <= {wdata_q[23:0], rx_readdata};
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            S_BUS: begin
               if (!avm_waitrequest) begin
                  if (is_write) begin
                     resp_q   <= {ACK_BYTE, 24'h0};
                     resp_len <= 3'd1;
                  end else begin
                     resp_q   <= avm_readdata;
                     resp_len <= 3'd4;
                  end
               end
            end
            S_RESP: begin
               if (tx_write) begin
                  resp_q   <= {resp_q[23:0], 8'h00};
                  resp_len <= resp_len - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_mm_cmd_master.sv
// Bench for jtag_mm_cmd_master: frame-level reference model with a
// per-cycle scoreboard on bus and tx traffic, plus directed scenarios.
module tb_jtag_mm_cmd_master;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } bus_t;

   logic        clk;
   logic        rst;
   logic        rx_dataavailable;
   logic [7:0]  rx_readdata;
   logic        tx_write;
   logic [7:0]  tx_writedata;
   logic        tx_readyfordata;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        err_overrun;
   logic        err_badcmd;
   logic        err_timeout;

   int checks = 0;
   int failures = 0;

   bus_t       exp_bus[$];
   logic [7:0] exp_tx[$];
   logic [7:0] tx_log[$];
   int exp_badcmd = 0, exp_overrun = 0, exp_timeout = 0;
   int n_badcmd = 0, n_overrun = 0, n_timeout = 0;
   int acc_n = 0, req_w = 0, last_w = 0;
   logic [31:0] last_addr, last_wdata;
   logic prev_tx = 0, prev_acc = 0;
   logic prev_eo = 0, prev_eb = 0, prev_et = 0;

   jtag_mm_cmd_master #(
      .TIMEOUT_CYCLES(20)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .rx_dataavailable (rx_dataavailable),
      .rx_readdata      (rx_readdata),
      .tx_write         (tx_write),
      .tx_writedata     (tx_writedata),
      .tx_readyfordata  (tx_readyfordata),
      .avm_address      (avm_address),
      .avm_read         (avm_read),
      .avm_write        (avm_write),
      .avm_writedata    (avm_writedata),
      .avm_readdata     (avm_readdata),
      .avm_waitrequest  (avm_waitrequest),
      .err_overrun      (err_overrun),
      .err_badcmd       (err_badcmd),
      .err_timeout      (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s act=%h want=%h", name, act, want);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s act=event want=none", name);
   endtask

   // Reference model: what a whole frame must produce on bus and tx.
   task automatic model_frame(input bq_t f);
      bus_t b;
      b.wr   = (f[0] == 8'h01);
      b.addr = (32'(f[1]) << 24) + (32'(f[2]) << 16) +
               (32'(f[3]) << 8) + 32'(f[4]);
      b.data = 0;
      if (f[0] == 8'h00) begin
         exp_bus.push_back(b);
         for (int i = 3; i >= 0; i--)
            exp_tx.push_back(8'((avm_readdata >> (8 * i)) & 32'hFF));
      end else if (f[0] == 8'h01) begin
         b.data = (32'(f[5]) << 24) + (32'(f[6]) << 16) +
                  (32'(f[7]) << 8) + 32'(f[8]);
         exp_bus.push_back(b);
         exp_tx.push_back(8'hA5);
      end else begin
         exp_tx.push_back(8'hEE);
         exp_badcmd++;
      end
   endtask

   task automatic send(input bq_t f);
      for (int i = 0; i <= f.size(); i++) begin
         rx_dataavailable = (i < f.size());
         if (i > 0) rx_readdata = f[i-1];
         @(posedge clk); #1;
      end
      rx_dataavailable = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= budget) fail("wait_done_timeout");
      repeat (3) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_tx  = 0;
         prev_acc = 0;
         req_w    = 0;
      end else begin
         if (tx_write) begin
            chk("tx_ready", tx_readyfordata, 1);
            chk("tx_gap", prev_tx, 0);
            tx_log.push_back(tx_writedata);
            if (exp_tx.size() == 0) fail("tx_extra");
            else chk("tx_byte", tx_writedata, exp_tx.pop_front());
         end
         if (avm_read || avm_write) begin
            chk("req_onehot", avm_read & avm_write, 0);
            if (prev_acc) fail("req_not_dropped");
            req_w++;
            if (!avm_waitrequest) begin
               bus_t e;
               acc_n++;
               last_w     = req_w;
               req_w      = 0;
               last_addr  = avm_address;
               last_wdata = avm_writedata;
               prev_acc   = 1;
               if (exp_bus.size() == 0) fail("bus_extra");
               else begin
                  e = exp_bus.pop_front();
                  chk("bus_kind", avm_write, e.wr);
                  chk("bus_addr", avm_address, e.addr);
                  if (e.wr) chk("bus_wdata", avm_writedata, e.data);
               end
            end else prev_acc = 0;
         end else prev_acc = 0;
         prev_tx = tx_write;
         if (err_overrun) begin
            if (prev_eo) fail("overrun_width");
            n_overrun++;
         end
         if (err_badcmd) begin
            if (prev_eb) fail("badcmd_width");
            n_badcmd++;
         end
         if (err_timeout) begin
            if (prev_et) fail("timeout_width");
            n_timeout++;
         end
         prev_eo = err_overrun;
         prev_eb = err_badcmd;
         prev_et = err_timeout;
      end
   end

   initial begin
      bq_t f;
      int t0, a0, k0;
      rst = 1'b1;
      rx_dataavailable = 1'b0;
      rx_readdata = 8'h00;
      tx_readyfordata = 1'b1;
      avm_readdata = 32'h0;
      avm_waitrequest = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctl", {avm_read, avm_write, tx_write, err_overrun,
                      err_badcmd, err_timeout}, 0);
      chk("rst_addr", avm_address, 0);
      chk("rst_wdata", avm_writedata, 0);
      chk("rst_txdata", tx_writedata, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // write frame, zero-wait bus
      tx_log.delete();
      f = '{8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      model_frame(f);
      send(f);
      wait_done(200);
      chk("wr_width", last_w, 1);
      chk("wr_addr", last_addr, 32'h0000_1000);
      chk("wr_data", last_wdata, 32'hDEAD_BEEF);
      chk("wr_ntx", tx_log.size(), 1);
      chk("wr_ack", tx_log[0], 8'hA5);

      // read frame, 5-cycle stall
      tx_log.delete();
      avm_readdata = 32'h1234_5678;
      avm_waitrequest = 1'b1;
      f = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00};
      model_frame(f);
      send(f);
      @(negedge clk);
      chk("bus_latency", avm_read, 1);
      repeat (5) @(posedge clk);
      #1;
      avm_waitrequest = 1'b0;
      wait_done(200);
      chk("rd_width", last_w, 6);
      chk("rd_ntx", tx_log.size(), 4);
      chk("rd_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]},
          32'h1234_5678);

      // unknown command, then a normal read
      tx_log.delete();
      k0 = n_badcmd;
      f = '{8'h7F};
      model_frame(f);
      send(f);
      wait_done(100);
      chk("nak_byte", tx_log[0], 8'hEE);
      chk("badcmd_once", n_badcmd - k0, 1);
      avm_readdata = 32'hCAFE_F00D;
      f = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h04};
      model_frame(f);
      send(f);
      wait_done(200);
      chk("rd2_addr", last_addr, 32'h0000_2004);

      // frame abandoned after 20 idle cycles
      t0 = n_timeout;
      a0 = acc_n;
      f = '{8'h01, 8'h00, 8'h00};
      exp_timeout++;
      send(f);
      repeat (25) @(posedge clk);
      #1;
      chk("timeout_once", n_timeout - t0, 1);
      chk("timeout_nobus", acc_n - a0, 0);
      f = '{8'h01, 8'h80, 8'h00, 8'h00, 8'h0C, 8'h01, 8'h02, 8'h03, 8'h04};
      model_frame(f);
      send(f);
      wait_done(200);
      chk("wr2_addr", last_addr, 32'h8000_000C);
      chk("wr2_data", last_wdata, 32'h0102_0304);

      // overrun during stall, tx backpressure in response
      tx_log.delete();
      k0 = n_overrun;
      avm_readdata = 32'hA1B2_C3D4;
      avm_waitrequest = 1'b1;
      f = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
      model_frame(f);
      send(f);
      f = '{8'h55};
      exp_overrun++;
      send(f);
      repeat (2) @(posedge clk);
      #1;
      avm_waitrequest = 1'b0;
      tx_readyfordata = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("bp_no_tx", tx_log.size(), 0);
      tx_readyfordata = 1'b1;
      wait_done(200);
      chk("overrun_once", n_overrun - k0, 1);
      chk("bp_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]},
          32'hA1B2_C3D4);

      // reset while a read is stalled
      avm_waitrequest = 1'b1;
      f = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
      model_frame(f);
      send(f);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_bus.delete();
      exp_tx.delete();
      @(negedge clk);
      chk("rst2_ctl", {avm_read, avm_write, tx_write, err_overrun,
                       err_badcmd, err_timeout}, 0);
      chk("rst2_addr", avm_address, 0);
      chk("rst2_txdata", tx_writedata, 0);
      avm_waitrequest = 1'b0;
      @(posedge clk); #1;
      f = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      model_frame(f);
      send(f);
      wait_done(200);
      chk("wr3_addr", last_addr, 32'h0000_0044);
      chk("wr3_data", last_wdata, 32'h5566_7788);

      chk("tot_badcmd", n_badcmd, exp_badcmd);
      chk("tot_overrun", n_overrun, exp_overrun);
      chk("tot_timeout", n_timeout, exp_timeout);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
